block_mem_responder: RTL and testbench

//  Memory-side responder for the cache block load/store handshake. Serves one 32-bit cache block per request

---
 rtl/block_mem_responder_if.sv | 27 ++
 rtl/block_mem_responder.sv | 146 ++++++++++++++
 tb/tb_block_mem_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_mem_responder_if.sv
// Cache <-> memory block load/store handshake bundle.
// master = cache side, slave = memory responder side.
interface block_mem_responder_if #(
  parameter int unsigned D_WIDTH = 32
);
  localparam int unsigned A_WIDTH = 16;

  logic [A_WIDTH-1:0] address_in;
  logic [D_WIDTH-1:0] data_in;
  logic               load_req;
  logic               wren;
  logic               store_ack;
  logic [D_WIDTH-1:0] data_out;
  logic               load_completed;
  logic               store_completed;
  logic               addr_err;

  modport master (
    output address_in, data_in, load_req, wren, store_ack,
    input  data_out, load_completed, store_completed, addr_err
  );

  modport slave (
    input  address_in, data_in, load_req, wren, store_ack,
    output data_out, load_completed, store_completed, addr_err
  );
endinterface

// File: rtl/block_mem_responder.sv
// Memory-side responder: serves one block per request/complete/ack handshake after LATENCY cycles.
// Optional MEM_RANGE_CHECK_EN adds a sticky out-of-range address flag (addr_err).
module block_mem_responder #(
  parameter int unsigned D_WIDTH    = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  block_mem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "block_mem_responder: LATENCY must be within 1..15");
  end

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    LD_DONE,
    ST_WAIT,
    ST_DONE,
    ST_REL
  } state_t;

  logic [D_WIDTH-1:0]    mem [DEPTH];
  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [D_WIDTH-1:0]    wdata;
  logic [D_WIDTH-1:0]    data_out_q;
  logic                  load_completed_q;
  logic                  store_completed_q;

  logic [DEPTH_LOG2-1:0] req_idx_c;
  logic                  accept_c;
  logic                  mem_we_c;
  logic                  unused_addr_bits;

  assign req_idx_c        = bus.address_in[DEPTH_LOG2+1:2];
  assign accept_c         = (state == IDLE) && (bus.wren || bus.load_req);
  assign unused_addr_bits = ^bus.address_in;

  // Write only on a live ST_WAIT expiry so a reset edge aborts the store cleanly.
  assign mem_we_c = rst_n && (state == ST_WAIT) && (cnt == '0);

  // Backing array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[idx] <= wdata;
    end
  end

  // Handshake state machine; address and store data are latched on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      data_out_q        <= '0;
      load_completed_q  <= 1'b0;
      store_completed_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.wren) begin
            idx   <= req_idx_c;
            wdata <= bus.data_in;
            cnt   <= CNT_LOAD;
            state <= ST_WAIT;
          end else if (bus.load_req) begin
            idx   <= req_idx_c;
            cnt   <= CNT_LOAD;
            state <= LD_WAIT;
          end
        end
        LD_WAIT: begin
          if (cnt == '0) begin
            data_out_q       <= mem[idx];
            load_completed_q <= 1'b1;
            state            <= LD_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LD_DONE: begin
          if (!bus.load_req) begin
            load_completed_q <= 1'b0;
            state            <= IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            store_completed_q <= 1'b1;
            state             <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.store_ack) begin
            store_completed_q <= 1'b0;
            state             <= ST_REL;
          end
        end
        // Hold off until the cache fully releases, so a lingering wren is not a second store.
        ST_REL: begin
          if (!bus.store_ack && !bus.wren) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out        = data_out_q;
  assign bus.load_completed  = load_completed_q;
  assign bus.store_completed = store_completed_q;

`ifdef MEM_RANGE_CHECK_EN
  logic addr_err_q;
  logic range_bad_c;

  assign range_bad_c = (bus.address_in >> (DEPTH_LOG2 + 2)) != '0;

  // Flag only; the transaction proceeds on the truncated index so the handshake never stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else if (accept_c && range_bad_c) begin
      addr_err_q <= 1'b1;
    end
  end

  assign bus.addr_err = addr_err_q;
`else
  logic unused_accept;
  assign unused_accept = accept_c;
  assign bus.addr_err  = 1'b0;
`endif

endmodule

// File: tb/tb_block_mem_responder.sv
// Bench for block_mem_responder: transaction-level reference model checked every cycle,
// directed handshake scenarios with literal expectations, then randomized traffic.
module tb_block_mem_responder;

  localparam int unsigned D_WIDTH    = 32;
  localparam int unsigned DEPTH_LOG2 = 10;
  localparam int unsigned LATENCY    = 2;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  block_mem_responder_if #(.D_WIDTH(D_WIDTH)) bus ();

  block_mem_responder #(
    .D_WIDTH   (D_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2),
    .LATENCY   (LATENCY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the cache should observe, tracked per transaction.
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  bit          exp_lc, exp_sc, exp_err;
  logic [31:0] exp_do;
  bit          exp_do_known;
  bit          busy, is_store, done, released;
  int unsigned cyc = 0;
  int unsigned done_at;
  int          m_idx;
  logic [31:0] m_data;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy = 1'b0; exp_lc = 1'b0; exp_sc = 1'b0; exp_err = 1'b0;
      exp_do = '0; exp_do_known = 1'b1;
    end else if (!busy) begin
      if (bus.wren || bus.load_req) begin
        busy     = 1'b1;
        is_store = bus.wren;
        done     = 1'b0;
        released = 1'b0;
        done_at  = cyc + LATENCY;
        m_idx    = int'((32'(bus.address_in) / 4) % DEPTH);
        m_data   = bus.data_in;
`ifdef MEM_RANGE_CHECK_EN
        if (32'(bus.address_in) >= (32'd1 << (DEPTH_LOG2 + 2))) exp_err = 1'b1;
`endif
      end
    end else if (!done) begin
      if (cyc == done_at) begin
        done = 1'b1;
        if (is_store) begin
          ref_mem[m_idx]   = m_data;
          ref_known[m_idx] = 1'b1;
          exp_sc           = 1'b1;
        end else begin
          exp_do       = ref_mem[m_idx];
          exp_do_known = ref_known[m_idx];
          exp_lc       = 1'b1;
        end
      end
    end else if (!is_store) begin
      if (!bus.load_req) begin exp_lc = 1'b0; busy = 1'b0; end
    end else if (!released) begin
      if (bus.store_ack) begin exp_sc = 1'b0; released = 1'b1; end
    end else if (!bus.store_ack && !bus.wren) begin
      busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("load_completed", 32'(bus.load_completed), 32'(exp_lc));
      chk("store_completed", 32'(bus.store_completed), 32'(exp_sc));
      chk("addr_err", 32'(bus.addr_err), 32'(exp_err));
      if (exp_do_known) chk("data_out", bus.data_out, exp_do);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after acceptance until the completion flag is seen; -1 on timeout.
  task automatic wait_flag(input bit want_store, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if ((want_store ? bus.store_completed : bus.load_completed) === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_%s: got timeout expected flag within 40 cycles", want_store ? "store" : "load");
    end
    #1;
  endtask

  task automatic do_store(input logic [15:0] addr, input logic [31:0] data);
    int lat;
    bus.address_in = addr; bus.data_in = data; bus.wren = 1'b1;
    tick();
    bus.address_in = addr ^ 16'h0040; bus.data_in = ~data;
    wait_flag(1'b1, lat);
    chk("store_latency", 32'(lat), 32'(LATENCY));
    tick();
    bus.store_ack = 1'b1; bus.wren = 1'b0;
    tick();
    chk("store_fall", 32'(bus.store_completed), 32'd0);
    bus.store_ack = 1'b0;
    tick();
  endtask

  task automatic do_load(input logic [15:0] addr, output logic [31:0] d);
    int lat;
    bus.address_in = addr; bus.load_req = 1'b1;
    tick();
    bus.address_in = addr ^ 16'h0080;
    wait_flag(1'b0, lat);
    chk("load_latency", 32'(lat), 32'(LATENCY));
    d = bus.data_out;
    tick();
    bus.load_req = 1'b0;
    tick();
    chk("load_fall", 32'(bus.load_completed), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int lat;
    bus.address_in = '0; bus.data_in = '0; bus.load_req = 1'b0;
    bus.wren = 1'b0; bus.store_ack = 1'b0;

    // Reset held two cycles, then five idle cycles.
    @(posedge clk); cmp_en = 1'b1; #1;
    tick();
    chk("rst_lc", 32'(bus.load_completed), 32'd0);
    chk("rst_sc", 32'(bus.store_completed), 32'd0);
    chk("rst_do", bus.data_out, 32'd0);
    chk("rst_err", 32'(bus.addr_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_do", bus.data_out, 32'd0);

    // Store then load back.
    do_store(16'h0008, 32'h0000DEAD);
    do_load(16'h0008, d);
    chk("load_dead", d, 32'h0000DEAD);

    // Simultaneous store and load: store first, load served afterwards.
    bus.address_in = 16'h0004; bus.data_in = 32'h01000100;
    bus.wren = 1'b1; bus.load_req = 1'b1;
    tick();
    wait_flag(1'b1, lat);
    chk("cont_store_lat", 32'(lat), 32'(LATENCY));
    tick();
    bus.store_ack = 1'b1; bus.wren = 1'b0;
    tick();
    bus.store_ack = 1'b0;
    tick();
    tick();
    wait_flag(1'b0, lat);
    chk("cont_load_lat", 32'(lat), 32'(LATENCY));
    chk("cont_data", bus.data_out, 32'h01000100);
    tick();
    bus.load_req = 1'b0;
    tick();
    tick();

    // Held ack with wren still high: no second write, no new acceptance.
    bus.address_in = 16'h0020; bus.data_in = 32'hCAFEF00D; bus.wren = 1'b1;
    tick();
    wait_flag(1'b1, lat);
    tick();
    bus.store_ack = 1'b1; bus.data_in = 32'h0BADBAD0; bus.load_req = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_sc", 32'(bus.store_completed), 32'd0);
      chk("held_lc", 32'(bus.load_completed), 32'd0);
    end
    bus.store_ack = 1'b0; bus.wren = 1'b0; bus.load_req = 1'b0;
    tick();
    tick();
    do_load(16'h0020, d);
    chk("held_data", d, 32'hCAFEF00D);

    // Reset during ST_WAIT leaves the old contents in place.
    do_store(16'h0010, 32'h12345678);
    bus.address_in = 16'h0010; bus.data_in = 32'hFFFFFFFF; bus.wren = 1'b1;
    tick();
    bus.wren = 1'b0; rst_n = 1'b0;
    tick();
    tick();
    chk("midrst_sc", 32'(bus.store_completed), 32'd0);
    chk("midrst_do", bus.data_out, 32'd0);
    rst_n = 1'b1;
    tick();
    do_load(16'h0010, d);
    chk("midrst_data", d, 32'h12345678);

    // Upper address bits: block 1 is returned either way; flag only with the check enabled.
    do_load(16'h1004, d);
    chk("range_data", d, 32'h01000100);
`ifdef MEM_RANGE_CHECK_EN
    chk("range_err", 32'(bus.addr_err), 32'd1);
    do_load(16'h0004, d);
    chk("range_sticky", 32'(bus.addr_err), 32'd1);
`else
    chk("range_err", 32'(bus.addr_err), 32'd0);
`endif

    // Randomized traffic, including occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a[15] = 1'b1;
      bus.address_in = a;
      bus.data_in    = $urandom;
      bus.wren       = ($urandom_range(0, 99) < 25);
      bus.load_req   = ($urandom_range(0, 99) < 45);
      bus.store_ack  = ($urandom_range(0, 99) < 35);
      rst_n          = ($urandom_range(0, 199) != 0);
      tick();
    end
    bus.wren = 1'b0; bus.load_req = 1'b0; bus.store_ack = 1'b0; rst_n = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
